mc_controller: RTL

- Multicycle control unit for the ARMv4-subset core: data-processing ADD/SUB/AND/ORR, LDR/STR and B.
- Sequences a shared-memory multicycle datapath (IR, A/B, ALUOut and Data registers) with a Moore main FSM, an ALU decoder and registered condition logic.
- Adds a memory-ready handshake and a retired-instruction counter.
- Sits between instruction register and datapath, in place of the single-cycle controller.

---
 rtl/mc_controller_if.sv | 34 +++
 rtl/mc_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The ctrl modport is the controller side and the dp modport is the datapath side.
interface mc_controller_if #(
  parameter int CNT_W = 32
) ();
  logic [31:12]    Instr;
  logic [3:0]      ALUFlags;
  logic            mem_ready;
  logic            PCWrite;
  logic            AdrSrc;
  logic            MemWrite;
  logic            IRWrite;
  logic [1:0]      ResultSrc;
  logic [1:0]      ALUControl;
  logic            ALUSrcA;
  logic [1:0]      ALUSrcB;
  logic [1:0]      ImmSrc;
  logic [1:0]      RegSrc;
  logic            RegWrite;
  logic [3:0]      state;
  logic [CNT_W-1:0] instr_count;

  modport ctrl (
    input  Instr, ALUFlags, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, state, instr_count
  );

  modport dp (
    output Instr, ALUFlags, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, RegWrite, state, instr_count
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARMv4-subset controller: Moore main FSM, ALU decoder, registered condition logic.
// Optional build macro MC_CMP_EN adds CMP (flag-only SUB that skips the writeback state).
module mc_controller #(
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          reset,
  mc_controller_if.ctrl bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg;
  logic [3:0]       flags_reg;   // {N,Z,C,V}
  logic             condex_q;
  logic [CNT_W-1:0] count_reg;

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond;
  logic [3:0] rd;
  logic [3:0] unused_rn;

  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign cond      = bus.Instr[31:28];
  assign rd        = bus.Instr[15:12];
  assign unused_rn = bus.Instr[19:16];

  // ALU decoder; cmd_addsub marks commands whose C/V flags are meaningful
  logic [1:0] alu_dec;
  logic       cmd_addsub;
  logic       is_cmp;

`ifdef MC_CMP_EN
  assign is_cmp = (op == 2'b00) && (funct[4:1] == 4'b1010);
`else
  assign is_cmp = 1'b0;
`endif

  always_comb begin
    alu_dec    = 2'b00;
    cmd_addsub = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 2'b00; cmd_addsub = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; cmd_addsub = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      default: alu_dec = 2'b00;
    endcase
    if (is_cmp) begin
      alu_dec    = 2'b01;
      cmd_addsub = 1'b1;
    end
  end

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = ~z;
      4'b0010: cond_pass = cy;
      4'b0011: cond_pass = ~cy;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = ~n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = ~v;
      4'b1000: cond_pass = cy & ~z;
      4'b1001: cond_pass = ~cy | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = ~z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= FETCH;
      flags_reg <= 4'b0000;
      condex_q  <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (bus.mem_ready) state_reg <= DECODE;
        end
        DECODE: begin
          // Sampled once here so an EXECUTE flag update cannot gate its own writeback
          condex_q <= cond_pass(cond, flags_reg);
          case (op)
            2'b01:   state_reg <= MEMADR;
            2'b00:   state_reg <= funct[5] ? EXECUTEI : EXECUTER;
            2'b10:   state_reg <= BRANCH;
            default: begin
              state_reg <= FETCH;
              count_reg <= count_reg + CNT_ONE;
            end
          endcase
        end
        MEMADR: begin
          state_reg <= funct[0] ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          if (bus.mem_ready) state_reg <= MEMWB;
        end
        EXECUTER, EXECUTEI: begin
          if (funct[0] && condex_q) begin
            flags_reg[3:2] <= bus.ALUFlags[3:2];
            if (cmd_addsub) flags_reg[1:0] <= bus.ALUFlags[1:0];
          end
          if (is_cmp) begin
            state_reg <= FETCH;
            count_reg <= count_reg + CNT_ONE;
          end else begin
            state_reg <= ALUWB;
          end
        end
        MEMWB, MEMWRITE, ALUWB, BRANCH: begin
          state_reg <= FETCH;
          count_reg <= count_reg + CNT_ONE;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  // Moore decode of the current state
  logic       next_pc, branch, reg_w, mem_w, alu_op;
  logic       adr_src, ir_write, alu_src_a;
  logic [1:0] result_src, alu_src_b;

  always_comb begin
    next_pc    = 1'b0;
    branch     = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    alu_op     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    alu_src_a  = 1'b0;
    result_src = 2'b00;
    alu_src_b  = 2'b00;
    case (state_reg)
      FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        next_pc    = bus.mem_ready;
      end
      DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      MEMADR:   alu_src_b = 2'b01;
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECUTER: alu_op = 1'b1;
      EXECUTEI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
      end
      ALUWB:    reg_w = 1'b1;
      BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
      end
      default: ;
    endcase
  end

  // Instruction-side writes are suppressed while reset abandons the instruction
  logic pcs;
  logic commit;
  assign pcs    = branch | (reg_w & (rd == 4'hF));
  assign commit = condex_q & ~reset;

  assign bus.PCWrite     = next_pc | (pcs & commit);
  assign bus.RegWrite    = reg_w & commit;
  assign bus.MemWrite    = mem_w & commit;
  assign bus.AdrSrc      = adr_src;
  assign bus.IRWrite     = ir_write;
  assign bus.ResultSrc   = result_src;
  assign bus.ALUControl  = alu_op ? alu_dec : 2'b00;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ImmSrc      = op;
  assign bus.RegSrc      = {op == 2'b01, op == 2'b10};
  assign bus.state       = state_reg;
  assign bus.instr_count = count_reg;

endmodule
